i2c_edid_reader: RTL and testbench

//  I2C controller (initiator) that reads EDID bytes from a downstream sink's DDC bus.

---
 rtl/i2c_edid_reader_if.sv | 32 +++
 rtl/i2c_edid_reader.sv | 190 +++++++++++++++++++
 tb/tb_i2c_edid_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_edid_reader_if.sv
// Bus/handshake bundle for i2c_edid_reader.
//  master : the reader side. It takes start/offset/length and the pin levels,
//           and drives status, read data and the open-drain enables.
//  slave  : the opposite view, used by whatever hosts the reader
//           (request logic, pad ring, or a bench).
//  Signals: start, offset[7:0], length[8:0], busy, done, nack_error,
//           rd_data[7:0], rd_addr[7:0], rd_strobe, scl_in, scl_oe, sda_in, sda_oe
interface i2c_edid_reader_if;
  logic       start;
  logic [7:0] offset;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic       nack_error;
  logic [7:0] rd_data;
  logic [7:0] rd_addr;
  logic       rd_strobe;
  logic       scl_in;
  logic       scl_oe;
  logic       sda_in;
  logic       sda_oe;

  modport master (
    input  start, offset, length, scl_in, sda_in,
    output busy, done, nack_error, rd_data, rd_addr, rd_strobe, scl_oe, sda_oe
  );

  modport slave (
    output start, offset, length, scl_in, sda_in,
    input  busy, done, nack_error, rd_data, rd_addr, rd_strobe, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_edid_reader.sv
// I2C initiator that reads EDID bytes from a DDC sink.
// One transaction is: START, dev+W, offset, repeated START, dev+R,
// N bytes with the last one NACKed, then STOP.
// Ports:
//  clk, reset_n   system clock and asynchronous active-low reset
//  bus (master)   start/offset/length request
//                 busy/done/nack_error status
//                 rd_data/rd_addr/rd_strobe byte output
//                 scl/sda pin levels in and open-drain enables out (oe=1 pulls low)
// Each bit is four quarter phases, each CLK_DIV clk cycles long:
//  Q0 SCL low, SDA set; Q1 SCL released; Q2 SCL high, sample; Q3 SCL low.
module i2c_edid_reader #(
  parameter int         CLK_DIV  = 15,
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic             clk,
  input  logic             reset_n,
  i2c_edid_reader_if.master bus
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, TX_ACK, RSTART, RX_BYTE, RX_ACK, STOP, DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_sel;   // 0: dev+W, 1: offset, 2: dev+R
  logic [7:0]    off_r;
  logic [8:0]    len_r;
  logic [8:0]    idx;        // bytes received so far
  logic [7:0]    rx_sr;
  logic          ack_ok;
  logic          nack_r;
  logic          strobe_r;
  logic [7:0]    rd_data_r;
  logic [7:0]    rd_addr_r;

  logic          tick, hold, smp, bit_state, bit_end, last_byte, accept, scl_low_q;
  logic [7:0]    tx_byte;
  logic          scl_oe_c, sda_oe_c;

  always_comb begin
    accept    = (state == IDLE) && bus.start;
    bit_state = state inside {TX_BYTE, TX_ACK, RX_BYTE, RX_ACK};
    tick      = (cnt == CW'(CLK_DIV - 1));
    bit_end   = tick && (q == 2'd3);
    scl_low_q = (q == 2'd0) || (q == 2'd3);
    last_byte = (idx == len_r);
    case (byte_sel)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = off_r;
      default: tx_byte = {DEV_ADDR, 1'b1};
    endcase
  end

  // Pin enables are pure decode of state/phase, so an async reset
  // releases the bus in the same cycle.
  always_comb begin
    scl_oe_c = 1'b0;
    sda_oe_c = 1'b0;
    case (state)
      START: if (len_r != 9'd0) begin
        sda_oe_c = 1'b1;              // SDA falls while SCL high
        scl_oe_c = (q == 2'd1);
      end
      TX_BYTE: begin
        scl_oe_c = scl_low_q;
        sda_oe_c = !tx_byte[3'd7 - bit_cnt];
      end
      TX_ACK, RX_BYTE: scl_oe_c = scl_low_q;
      RX_ACK: begin
        scl_oe_c = scl_low_q;
        sda_oe_c = !last_byte;        // ACK all but the final byte
      end
      RSTART: begin                   // SDA up, SCL up, SDA down, SCL down
        scl_oe_c = scl_low_q;
        sda_oe_c = q[1];
      end
      STOP: begin                     // SDA low, SCL up, SDA up
        scl_oe_c = (q == 2'd0);
        sda_oe_c = (q != 2'd2);
      end
      default: ;
    endcase
  end

  // A sink stretching SCL freezes the prescaler at the start of Q2;
  // the Q2 sample is taken on the first cycle SCL is seen high.
  always_comb begin
    hold = (q == 2'd2) && (cnt == '0) && !scl_oe_c && !bus.scl_in &&
           !(state inside {IDLE, DONE});
    smp  = bit_state && (q == 2'd2) && (cnt == '0) && bus.scl_in;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = START;
      START:   if (len_r == 9'd0) state_nx = DONE;
               else if (tick && q == 2'd1) state_nx = TX_BYTE;
      TX_BYTE: if (bit_end && bit_cnt == 3'd7) state_nx = TX_ACK;
      TX_ACK:  if (bit_end) begin
                 if (!ack_ok)               state_nx = STOP;
                 else if (byte_sel == 2'd0) state_nx = TX_BYTE;
                 else if (byte_sel == 2'd1) state_nx = RSTART;
                 else                       state_nx = RX_BYTE;
               end
      RSTART:  if (tick && q == 2'd3) state_nx = TX_BYTE;
      RX_BYTE: if (bit_end && bit_cnt == 3'd7) state_nx = RX_ACK;
      RX_ACK:  if (bit_end) state_nx = last_byte ? STOP : RX_BYTE;
      STOP:    if (tick && q == 2'd2) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      q         <= '0;
      bit_cnt   <= '0;
      byte_sel  <= '0;
      off_r     <= '0;
      len_r     <= '0;
      idx       <= '0;
      rx_sr     <= '0;
      ack_ok    <= 1'b0;
      nack_r    <= 1'b0;
      strobe_r  <= 1'b0;
      rd_data_r <= '0;
      rd_addr_r <= '0;
    end else begin
      strobe_r <= 1'b0;

      if (state inside {IDLE, DONE}) begin
        cnt <= '0;
        q   <= '0;
      end else if (!hold) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) q <= (state_nx != state) ? 2'd0 : q + 2'd1;
      end

      if (accept) begin
        off_r    <= bus.offset;
        len_r    <= bus.length;
        idx      <= '0;
        bit_cnt  <= '0;
        byte_sel <= '0;
        nack_r   <= 1'b0;
      end

      if (bit_end && (state == TX_BYTE || state == RX_BYTE))
        bit_cnt <= bit_cnt + 3'd1;

      if (smp && state == TX_ACK) ack_ok <= !bus.sda_in;

      if (bit_end && state == TX_ACK) begin
        if (ack_ok) byte_sel <= byte_sel + 2'd1;
        else        nack_r   <= 1'b1;
      end

      if (smp && state == RX_BYTE) begin
        rx_sr <= {rx_sr[6:0], bus.sda_in};
        if (bit_cnt == 3'd7) begin
          strobe_r  <= 1'b1;
          rd_data_r <= {rx_sr[6:0], bus.sda_in};
          rd_addr_r <= off_r + idx[7:0];
          idx       <= idx + 9'd1;
        end
      end
    end
  end

  assign bus.busy       = !(state inside {IDLE, DONE});
  assign bus.done       = (state == DONE);
  assign bus.nack_error = nack_r;
  assign bus.rd_strobe  = strobe_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.scl_oe     = scl_oe_c;
  assign bus.sda_oe     = sda_oe_c;
endmodule

// File: tb/tb_i2c_edid_reader.sv
// Bench for i2c_edid_reader: an event-level EEPROM slave on a wired-AND bus,
// a queue model of expected reads, and directed scenarios.
module tb_i2c_edid_reader;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2c_edid_reader_if bus();

  logic s_sda_low = 1'b0, s_scl_low = 1'b0;
  wire scl = !(bus.scl_oe || s_scl_low);
  wire sda = !(bus.sda_oe || s_sda_low);
  assign bus.scl_in = scl;
  assign bus.sda_in = sda;

  i2c_edid_reader #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h50)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int ntests = 0, nfail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // ---------------- slave EEPROM on the bus ----------------
  bit slave_present = 1, stretch_en = 0;
  int bitn = -1;
  logic [7:0] sh, ptr, cur;
  bit expect_addr, s2m, active, addr_ack, rd_mode, mack;
  logic [7:0] bus_log[$];
  int n_start, n_stop, n_mack, n_mnack;
  int stretch_cnt, hi_cnt, hi_time, stretch_seen;
  bit meas;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic c_scl, c_sda;

  task automatic slave_reset();
    bitn = -1; expect_addr = 0; s2m = 0; active = 0;
    s_sda_low = 0; s_scl_low = 0; meas = 0;
    prev_scl = 1'b1; prev_sda = 1'b1;
  endtask

  always @(negedge clk) begin
    c_scl = scl;
    c_sda = sda;
    if (s_scl_low) begin
      if (!bus.scl_oe) stretch_seen++;
      stretch_cnt--;
      if (stretch_cnt == 0) begin s_scl_low = 0; meas = 1; hi_cnt = 1; end
    end else if (meas) begin
      if (c_scl) hi_cnt++;
      else begin meas = 0; hi_time = hi_cnt; end
    end

    if (prev_scl && c_scl && prev_sda && !c_sda) begin
      n_start++; bitn = -1; expect_addr = 1; s2m = 0; s_sda_low = 0; active = 1;
    end else if (prev_scl && c_scl && !prev_sda && c_sda) begin
      n_stop++; active = 0; s2m = 0; s_sda_low = 0; bitn = -1;
    end else if (active && !prev_scl && c_scl) begin
      if (bitn >= 0 && bitn < 8 && !s2m) sh = {sh[6:0], c_sda};
      else if (bitn == 8 && s2m) mack = !c_sda;
    end else if (active && prev_scl && !c_scl) begin
      if (bitn < 0) bitn = 0;
      else begin
        bitn++;
        if (stretch_en && n_start == 2 && expect_addr && !s2m && bitn == 3) begin
          s_scl_low = 1; stretch_cnt = 200; stretch_en = 0;
        end
        if (bitn == 8) begin
          if (!s2m) begin
            bus_log.push_back(sh);
            if (expect_addr) begin
              addr_ack  = slave_present && (sh[7:1] == 7'h50);
              rd_mode   = sh[0];
              s_sda_low = addr_ack;
            end else begin
              ptr = sh;
              s_sda_low = slave_present;
            end
          end else s_sda_low = 0;
        end else if (bitn == 9) begin
          bitn = 0;
          if (!s2m) begin
            s_sda_low = 0;
            if (expect_addr) begin
              expect_addr = 0;
              if (!addr_ack) active = 0;
              else if (rd_mode) begin s2m = 1; cur = mem(ptr); s_sda_low = !cur[7]; end
            end
          end else if (mack) begin
            n_mack++; ptr++; cur = mem(ptr); s_sda_low = !cur[7];
          end else begin
            n_mnack++; s2m = 0; active = 0;
          end
        end else if (s2m) s_sda_low = !cur[7 - bitn];
      end
    end
    prev_scl = c_scl;
    prev_sda = c_sda;
  end

  // ---------------- read model and compare process ----------------
  typedef struct packed { logic [7:0] a; logic [7:0] d; } rd_t;
  rd_t exp_q[$];
  rd_t e_rd;
  logic [7:0] log_a[$], log_d[$];
  int n_done;
  bit exp_nack;

  task automatic expect_read(input logic [7:0] off, input int len);
    rd_t e;
    for (int i = 0; i < len; i++) begin
      e.a = off + 8'(i);
      e.d = e.a ^ 8'hA5;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rd_strobe) begin
        log_a.push_back(bus.rd_addr);
        log_d.push_back(bus.rd_data);
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_rd = exp_q.pop_front();
          check("rd_addr", bus.rd_addr, e_rd.a);
          check("rd_data", bus.rd_data, e_rd.d);
        end
      end
      if (bus.done) begin
        n_done++;
        check("busy_at_done", bus.busy, 0);
        check("nack_error_at_done", bus.nack_error, exp_nack);
        check("strobes_missing", exp_q.size(), 0);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  logic nack_at_start;

  task automatic run(input logic [7:0] off, input logic [8:0] len, input bit present);
    int cyc;
    slave_present = present;
    exp_nack = !present && (len != 0);
    if (present) expect_read(off, int'(len));
    n_start = 0; n_stop = 0; n_mack = 0; n_mnack = 0; n_done = 0;
    bus_log.delete(); log_a.delete(); log_d.delete();
    @(negedge clk);
    bus.offset = off; bus.length = len; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    nack_at_start = bus.nack_error;
    cyc = 0;
    while (!bus.done && cyc < 60000) begin @(negedge clk); cyc++; end
    check("done_timeout", cyc < 60000, 1);
    repeat (5) @(negedge clk);
    check("done_once", n_done, 1);
  endtask

  initial begin
    int cyc;
    bus.start = 0; bus.offset = 0; bus.length = 0;
    #1;
    check("rst_scl_oe", bus.scl_oe, 0);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_strobe", bus.rd_strobe, 0);
    check("rst_nack", bus.nack_error, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;

    // 1: basic read of 4 bytes
    run(8'h00, 9'd4, 1);
    check("t1_nstrobe", log_d.size(), 4);
    if (log_d.size() == 4) begin
      check("t1_d0", log_d[0], 8'hA5);
      check("t1_d1", log_d[1], 8'hA4);
      check("t1_d2", log_d[2], 8'hA7);
      check("t1_d3", log_d[3], 8'hA6);
      check("t1_a3", log_a[3], 8'h03);
    end
    check("t1_buslog_n", bus_log.size(), 3);
    if (bus_log.size() == 3) begin
      check("t1_devw", bus_log[0], 8'hA0);
      check("t1_off", bus_log[1], 8'h00);
      check("t1_devr", bus_log[2], 8'hA1);
    end
    check("t1_starts", n_start, 2);
    check("t1_stops", n_stop, 1);
    check("t1_master_acks", n_mack, 3);
    check("t1_master_nacks", n_mnack, 1);
    check("t1_nack_error", bus.nack_error, 0);

    // 2: no slave, then recovery
    run(8'h00, 9'd8, 0);
    check("t2_nack_error", bus.nack_error, 1);
    check("t2_nstrobe", log_a.size(), 0);
    check("t2_buslog_n", bus_log.size(), 1);
    if (bus_log.size() == 1) check("t2_devw", bus_log[0], 8'hA0);
    check("t2_starts", n_start, 1);
    check("t2_stops", n_stop, 1);
    run(8'h20, 9'd2, 1);
    check("t2_nack_cleared_on_start", nack_at_start, 0);
    check("t2_nack_after", bus.nack_error, 0);

    // 3: address wrap
    run(8'hFE, 9'd3, 1);
    check("t3_nstrobe", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("t3_a0", log_a[0], 8'hFE);
      check("t3_a1", log_a[1], 8'hFF);
      check("t3_a2", log_a[2], 8'h00);
      check("t3_d2", log_d[2], 8'hA5);
    end
    if (bus_log.size() > 1) check("t3_off_byte", bus_log[1], 8'hFE);
    else check("t3_buslog_n", bus_log.size(), 3);

    // 4: clock stretch inside dev+R
    stretch_seen = 0; hi_time = 0; stretch_en = 1;
    run(8'h10, 9'd2, 1);
    check("t4_stretched", stretch_seen > 150, 1);
    check("t4_high_after_release", hi_time >= CLK_DIV, 1);
    if (bus_log.size() == 3) check("t4_devr", bus_log[2], 8'hA1);
    else check("t4_buslog_n", bus_log.size(), 3);
    if (log_d.size() > 0) check("t4_d0", log_d[0], 8'hB5);
    else check("t4_nstrobe", log_d.size(), 2);

    // 5a: zero length
    exp_nack = 0; n_done = 0;
    @(negedge clk);
    bus.length = 9'd0; bus.offset = 8'h33; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    check("t5_busy_c1", bus.busy, 1);
    check("t5_done_c1", bus.done, 0);
    check("t5_oe_c1", {bus.scl_oe, bus.sda_oe}, 0);
    @(negedge clk);
    check("t5_busy_c2", bus.busy, 0);
    check("t5_done_c2", bus.done, 1);
    check("t5_oe_c2", {bus.scl_oe, bus.sda_oe}, 0);
    @(negedge clk);
    check("t5_done_c3", bus.done, 0);

    // 5b: full 256-byte read, with a start pulse mid-transaction that must be ignored
    fork
      run(8'h00, 9'd256, 1);
      begin
        repeat (600) @(negedge clk);
        bus.start = 1; bus.offset = 8'h77; bus.length = 9'd1;
        @(negedge clk);
        bus.start = 0;
      end
    join
    check("t5_nstrobe", log_a.size(), 256);
    check("t5_master_acks", n_mack, 255);
    check("t5_master_nacks", n_mnack, 1);
    if (log_a.size() == 256) check("t5_last_addr", log_a[255], 8'hFF);

    // 6: reset mid RX_BYTE
    slave_present = 1; exp_nack = 0;
    expect_read(8'h00, 4);
    log_a.delete(); log_d.delete();
    @(negedge clk);
    bus.offset = 8'h00; bus.length = 9'd4; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    cyc = 0;
    while (log_a.size() < 1 && cyc < 5000) begin @(negedge clk); cyc++; end
    check("t6_first_byte_timeout", cyc < 5000, 1);
    repeat (20) @(negedge clk);
    cyc = 0;
    while (!bus.scl_oe && cyc < 100) begin @(negedge clk); cyc++; end
    check("t6_pre_scl_oe", bus.scl_oe, 1);
    check("t6_pre_busy", bus.busy, 1);
    #2 reset_n = 0;
    #1;
    check("t6_scl_oe", bus.scl_oe, 0);
    check("t6_sda_oe", bus.sda_oe, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_strobe", bus.rd_strobe, 0);
    slave_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1;
    run(8'h40, 9'd2, 1);
    check("t6_after_nstrobe", log_a.size(), 2);
    if (log_d.size() == 2) check("t6_after_d1", log_d[1], 8'hE4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #3000000;
    nfail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $fatal(1);
  end
endmodule
